// File: rtl/w4823_fir_sched.sv
// Tap scheduler for the W4823 FP16 FIR: writes each new sample into the circular
// delay line, then walks NTAPS coefficient/data pairs through the MAC and flags completion.
module w4823_fir_sched #(
    parameter int NTAPS   = 65,
    parameter int CADDR_W = 7,
    parameter int DADDR_W = 7,
    parameter int MAC_LAT = 4
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               en_i,
    input  logic               sample_tick_i,
    input  logic               cload_busy_i,
    input  logic               ovr_clr_i,
    output logic               dmem_we_o,
    output logic [DADDR_W-1:0] dmem_waddr_o,
    output logic [DADDR_W-1:0] dmem_raddr_o,
    output logic [CADDR_W-1:0] cmem_raddr_o,
    output logic               mac_en_o,
    output logic               acc_clr_o,
    output logic               last_tap_o,
    output logic               out_valid_o,
    output logic               busy_o,
    output logic               overrun_o
);

    // state | meaning
    // IDLE  | waiting for a sample tick (or a held-off pending start)
    // WRITE | new sample written at wp, base latched
    // MAC   | tap k = 0..NTAPS-1 presented to the MAC
    // DRAIN | MAC pipeline flushing, MAC_LAT cycles
    // DONE  | accumulator result valid for one cycle
    typedef enum logic [2:0] {IDLE, WRITE, MAC, DRAIN, DONE} state_t;

    localparam int                 DW       = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [CADDR_W-1:0] LAST_K   = CADDR_W'(NTAPS - 1);
    localparam logic [DW-1:0]      DRAIN_LD = DW'(MAC_LAT - 1);

    state_t             state_q;
    logic [DADDR_W-1:0] wp_q, base_q, wp_d;
    logic [CADDR_W-1:0] k_q, k_d;
    logic [DW-1:0]      drain_q;
    logic               pend_q;
    logic               dmem_we_q, mac_en_q, acc_clr_q, last_tap_q, out_valid_q, busy_q, ovr_q;
    logic [DADDR_W-1:0] dmem_waddr_q, dmem_raddr_q;
    logic [CADDR_W-1:0] cmem_raddr_q;

    assign wp_d = wp_q + DADDR_W'(1);
    assign k_d  = k_q + CADDR_W'(1);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            wp_q         <= '0;
            base_q       <= '0;
            k_q          <= '0;
            drain_q      <= '0;
            pend_q       <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_waddr_q <= '0;
            dmem_raddr_q <= '0;
            cmem_raddr_q <= '0;
            mac_en_q     <= 1'b0;
            acc_clr_q    <= 1'b0;
            last_tap_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            dmem_we_q   <= 1'b0;
            mac_en_q    <= 1'b0;
            acc_clr_q   <= 1'b0;
            last_tap_q  <= 1'b0;
            out_valid_q <= 1'b0;

            // set has priority over clear
            if (ovr_clr_i) ovr_q <= 1'b0;
            if (sample_tick_i && busy_q) ovr_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (!en_i) begin
                        pend_q <= 1'b0;
                    end else if (sample_tick_i || pend_q) begin
                        if (cload_busy_i) begin
                            pend_q <= 1'b1;
                        end else begin
                            pend_q       <= 1'b0;
                            state_q      <= WRITE;
                            busy_q       <= 1'b1;
                            dmem_we_q    <= 1'b1;
                            dmem_waddr_q <= wp_q;
                            base_q       <= wp_q;
                            wp_q         <= wp_d;
                        end
                    end
                end
                WRITE: begin
                    state_q      <= MAC;
                    k_q          <= '0;
                    mac_en_q     <= 1'b1;
                    acc_clr_q    <= 1'b1;
                    cmem_raddr_q <= '0;
                    dmem_raddr_q <= base_q;
                end
                MAC: begin
                    if (k_q == LAST_K) begin
                        state_q <= DRAIN;
                        drain_q <= DRAIN_LD;
                    end else begin
                        k_q          <= k_d;
                        mac_en_q     <= 1'b1;
                        cmem_raddr_q <= k_d;
                        dmem_raddr_q <= base_q - DADDR_W'(k_d);
                        last_tap_q   <= (k_d == LAST_K);
                    end
                end
                DRAIN: begin
                    if (drain_q == '0) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        drain_q <= drain_q - DW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dmem_we_o    = dmem_we_q;
    assign dmem_waddr_o = dmem_waddr_q;
    assign dmem_raddr_o = dmem_raddr_q;
    assign cmem_raddr_o = cmem_raddr_q;
    assign mac_en_o     = mac_en_q;
    assign acc_clr_o    = acc_clr_q;
    assign last_tap_o   = last_tap_q;
    assign out_valid_o  = out_valid_q;
    assign busy_o       = busy_q;
    assign overrun_o    = ovr_q;

endmodule

// File: doc/w4823_fir_sched.md
Name: w4823_fir_sched

Overview:
Tap scheduler for the W4823 FP16 FIR datapath, running in the fast clock domain.
- On each sample tick, writes the new din into the circular delay-line memory.
- Then sequences NTAPS coefficient/data read pairs into the MAC, waits out the MAC pipeline, and pulses out_valid.
- Holds off while coefficient memory is being loaded, and flags sample overruns.

Parameters:
- NTAPS, 65, number of taps = MAC cycles per sample (≥2).
- CADDR_W, 7, coefficient address width (2^CADDR_W ≥ NTAPS).
- DADDR_W, 7, delay-line address width (2^DADDR_W ≥ NTAPS).
- MAC_LAT, 4, MAC pipeline latency in clk cycles (≥1).

Ports:
- clk  in  1  fast clock.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  scheduler enable.
- sample_tick  in  1  one-cycle pulse per new input sample, already synchronous to clk.
- cload_busy  in  1  high while CMEM is being written; new runs are held off.
- ovr_clr  in  1  clears the sticky overrun flag.
- dmem_we  out  1  delay-line write strobe.
- dmem_waddr  out  DADDR_W  delay-line write address.
- dmem_raddr  out  DADDR_W  delay-line read address.
- cmem_raddr  out  CADDR_W  coefficient read address.
- mac_en  out  1  MAC accumulate enable.
- acc_clr  out  1  accumulator clear; coincident with tap 0.
- last_tap  out  1  marks tap NTAPS-1.
- out_valid  out  1  one-cycle pulse when the accumulator holds the finished sum.
- busy  out  1  a sample run is in progress.
- overrun  out  1  sticky flag: a tick arrived while busy.

Behaviour:
- Clock and reset:
  - Single clock clk.
  - rst_n is synchronous and active-low.
  - Reset forces state IDLE, wp=0, pending=0, tap counter=0, and all outputs 0.
- Outputs are registered. Each one is valid in the cycle of its state.
- FSM states: IDLE, WRITE, MAC, DRAIN, DONE.
- IDLE:
  - tick & en & ~cload_busy → WRITE next cycle.
  - tick & en & cload_busy → set pending; stay in IDLE.
  - pending & ~cload_busy → clear pending, go to WRITE.
  - tick & ~en → dropped; pending is not set.
  - If en falls while pending=1, pending is cleared.
- WRITE (1 cycle):
  - dmem_we=1, dmem_waddr=wp.
  - Latch base=wp; wp←wp+1, wrapping mod 2^DADDR_W.
  - Next state MAC, with k=0.
- MAC (NTAPS cycles, k=0..NTAPS-1):
  - mac_en=1.
  - cmem_raddr=k.
  - dmem_raddr=(base−k) mod 2^DADDR_W, so the newest sample pairs with coefficient 0.
  - acc_clr=1 only at k=0.
  - last_tap=1 only at k=NTAPS-1, after which the next state is DRAIN.
- DRAIN (MAC_LAT cycles): mac_en=0; addresses hold their last value.
- DONE (1 cycle): out_valid=1, then IDLE.
- Latency:
  - Tick accepted at cycle T → WRITE at T+1, MAC at T+2..T+1+NTAPS, out_valid at T+2+NTAPS+MAC_LAT.
  - With defaults, out_valid is at T+71.
- busy=1 in WRITE, MAC, DRAIN and DONE.
- Overrun:
  - sample_tick while busy=1 → tick ignored, overrun←1.
  - overrun holds until ovr_clr or reset.
  - A simultaneous tick and ovr_clr leaves overrun=1 (set wins).
- cload_busy rising mid-run does not abort the run; it only gates the next start.
- en falling mid-run: the current run completes normally.
- Reset mid-run: the run aborts, no out_valid is produced, and wp returns to 0.
- wp wrap: 2^DADDR_W−1 → 0. Read addresses wrap identically, e.g. base=2, k=5 → raddr=125.

Test Plan:
1. Reset, en=1, tick at cycle 10 → dmem_we at 11 with waddr=0; mac_en 12..76; acc_clr at 12; last_tap at 76; out_valid at 81; busy high 11..81.
2. Second tick at cycle 20 (mid-run) → overrun=1 from cycle 21, no extra run. Then ovr_clr → overrun=0 the next cycle.
3. 130 ticks spaced 128 cycles apart → waddr sequence 0..127,0,1. On the run with base=1: raddr at k=0..3 = 1,0,127,126; cmem_raddr 0..64.
4. cload_busy=1 during a tick at 200, released at 260 → WRITE at 261, out_valid at 331.
5. en=0, tick → no dmem_we and pending stays 0. Then en=1 and tick → normal run.
6. rst_n=0 for 1 cycle at k=30 → all outputs 0 next cycle, no out_valid. Next tick writes waddr=0.
